nibble_serial_add_ctrl: RTL

//  Sequencer that time-shares one combinational 4-bit adder slice (FourBitAdder) to add WIDTH-bit operands.

---
 rtl/nibble_serial_add_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds WIDTH-bit operands one nibble per clock
// through a shared external 4-bit adder slice, carrying the ripple carry in a register.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             READY,
  output logic             BUSY,
  output logic [3:0]       ADD_A,
  output logic [3:0]       ADD_B,
  output logic             ADD_CIN,
  input  logic [3:0]       ADD_S,
  input  logic             ADD_COUT,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             DONE
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic [3:0]       nib_a, nib_b;
  logic             run;

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
    end
  end

  // Select the operand nibbles addressed by the pass index
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int n = 0; n < NIB; n++) begin
      if (idx_q == IW'(n)) begin
        nib_a = a_q[4*n +: 4];
        nib_b = b_q[4*n +: 4];
      end
    end
  end

  // Next-state logic: accept, one adder pass per cycle, publish result
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    res_d   = res_q;
    cout_d  = cout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          carry_d = C_in;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int n = 0; n < NIB; n++) begin
          if (idx_q == IW'(n)) begin
            s_d[4*n +: 4] = ADD_S;
          end
        end
        carry_d = ADD_COUT;
        if (idx_q == LAST) begin
          res_d   = s_d;
          cout_d  = ADD_COUT;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign run     = (state_q == ST_RUN);
  assign READY   = (state_q == ST_IDLE);
  assign BUSY    = !READY;
  assign DONE    = (state_q == ST_DONE);
  assign ADD_A   = run ? nib_a : 4'h0;
  assign ADD_B   = run ? nib_b : 4'h0;
  assign ADD_CIN = run & carry_q;
  assign S       = res_q;
  assign C_out   = cout_q;

endmodule
